// File: rtl/ntt_pkg.sv
// ============================================================================
// ntt_pkg : shared constants, FSM state type and mode helpers for the NTT
//           sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

package ntt_pkg;

  localparam int N            = 256;
  localparam int LOG_N        = 8;
  localparam int KYBER_LAYERS = 7;
  localparam int DIL_LAYERS   = 8;

  localparam logic SEL_KYBER = 1'b1;
  localparam logic SEL_CT    = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } ntt_state_t;

  // Kyber stops one layer early (s_min = 1); Dilithium runs down to s = 0.
  function automatic logic [2:0] s_min(input logic sel_red);
    return (sel_red == SEL_KYBER) ? 3'd1 : 3'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_addr_gen.sv
// ============================================================================
// ntt_addr_gen : combinational (c, s, dir) -> (a, b, twiddle) map for one
//                butterfly of an in-place NTT layer.  Rev 1.0
// ============================================================================
`default_nettype none

module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [6:0]       c,
  input  logic [2:0]       s,
  input  logic             inv,
  output logic [LOG_N-1:0] a,
  output logic [LOG_N-1:0] b,
  output logic [LOG_N-1:0] tw
);

  logic [LOG_N-1:0] c_ext;
  logic [LOG_N-1:0] low_mask;
  logic [LOG_N-1:0] g;

  always_comb begin
    c_ext    = {1'b0, c};
    low_mask = (8'd1 << s) - 8'd1;
    g        = c_ext >> s;
    // Insert a zero at bit s: high part (g << s) moves up by one position.
    a        = ((c_ext & ~low_mask) << 1) | (c_ext & low_mask);
    b        = a | (8'd1 << s);
    // (256 >> s) - 1 is exactly 8'hFF >> s, which keeps the math 8 bits wide.
    tw       = inv ? ((8'hFF >> s) - g) : ((8'd128 >> s) + g);
  end

endmodule

`default_nettype wire

// File: rtl/ntt_sequencer.sv
// ============================================================================
// ntt_sequencer : issues one butterfly per cycle for a full forward/inverse
//                 NTT layer sweep and delays addresses into write-backs. Rev 1.0
// ============================================================================
`default_nettype none

module ntt_sequencer
  import ntt_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       sel_red_i,
  input  logic       sel_butterfly_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [7:0] tw_addr_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o,
  output logic       sel_red_o,
  output logic       sel_butterfly_o
);

  localparam int D   = RD_LAT + BF_LAT;
  localparam int DW  = (D > 1) ? $clog2(D) : 1;
  localparam int BUS = 1 + 2 * LOG_N;

  ntt_state_t    state, state_nxt;
  logic [6:0]    cnt, cnt_nxt;
  logic [2:0]    stage, stage_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          mode_red, mode_red_nxt;
  logic          mode_inv, mode_inv_nxt;

  logic          last_layer;
  logic [2:0]    stage_adv;
  logic [7:0]    addr_a, addr_b, addr_tw;

  assign last_layer = mode_inv ? (stage == 3'd7) : (stage == s_min(mode_red));
  assign stage_adv  = mode_inv ? (stage + 3'd1) : (stage - 3'd1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      stage    <= '0;
      dcnt     <= '0;
      mode_red <= 1'b0;
      mode_inv <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stage    <= stage_nxt;
      dcnt     <= dcnt_nxt;
      mode_red <= mode_red_nxt;
      mode_inv <= mode_inv_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stage_nxt    = stage;
    dcnt_nxt     = dcnt;
    mode_red_nxt = mode_red;
    mode_inv_nxt = mode_inv;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt    = S_RUN;
          cnt_nxt      = '0;
          dcnt_nxt     = '0;
          mode_red_nxt = sel_red_i;
          mode_inv_nxt = (sel_butterfly_i != SEL_CT);
          stage_nxt    = (sel_butterfly_i != SEL_CT) ? s_min(sel_red_i) : 3'd7;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt + 7'd1;
        if (cnt == 7'd127) begin
          // With no pipeline latency the next layer can follow back-to-back.
          if (D == 0) begin
            if (last_layer) state_nxt = S_DONE;
            else            stage_nxt = stage_adv;
          end else begin
            state_nxt = S_DRAIN;
            dcnt_nxt  = '0;
          end
        end
      end
      S_DRAIN: begin
        dcnt_nxt = dcnt + 1'b1;
        if (dcnt == DW'(D - 1)) begin
          dcnt_nxt = '0;
          if (last_layer) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
            stage_nxt = stage_adv;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  ntt_addr_gen u_addr_gen (
    .c   (cnt),
    .s   (stage),
    .inv (mode_inv),
    .a   (addr_a),
    .b   (addr_b),
    .tw  (addr_tw)
  );

  assign busy_o          = (state == S_RUN) || (state == S_DRAIN);
  assign done_o          = (state == S_DONE);
  assign rd_en_o         = (state == S_RUN);
  assign rd_addr_a_o     = rd_en_o ? addr_a  : '0;
  assign rd_addr_b_o     = rd_en_o ? addr_b  : '0;
  assign tw_addr_o       = rd_en_o ? addr_tw : '0;
  assign sel_red_o       = mode_red;
  assign sel_butterfly_o = mode_inv;

  logic [BUS-1:0] rd_bus, wr_bus;
  assign rd_bus = {rd_en_o, rd_addr_a_o, rd_addr_b_o};

  if (D == 0) begin : g_no_delay
    assign wr_bus = rd_bus;
  end else begin : g_delay
    logic [BUS-1:0] pipe [D];
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < D; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= rd_bus;
        for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign wr_bus = pipe[D-1];
  end

  assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = wr_bus;

endmodule

`default_nettype wire

// File: doc/ntt_sequencer.md
# ntt_sequencer

Control block that runs a complete in-place NTT or inverse NTT over a 256-coefficient polynomial by issuing operand addresses, twiddle indices and mode selects to the `butterfly` datapath. It drives one butterfly per cycle and writes results back to the coefficient RAM. It supports Kyber and Dilithium with the butterfly's existing `sel_red` / `sel_butterfly` encoding, and sits between the top-level controller (start/done) and the coefficient RAM, twiddle ROM and butterfly.

## Interface
- `RD_LAT`, default 1: coefficient RAM / twiddle ROM read latency in cycles.
- `BF_LAT`, default 0: butterfly latency in cycles (0 = combinational).
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `start_i` in 1: start request. Sampled only in IDLE.
- `sel_red_i` in 1: 1 = Kyber (q=3329, 7 layers), 0 = Dilithium (q=8380417, 8 layers).
- `sel_butterfly_i` in 1: 0 = Cooley-Tukey forward NTT, 1 = Gentleman-Sande inverse NTT.
- `busy_o` out 1: high from the cycle after start until `done_o`.
- `done_o` out 1: one-cycle completion pulse.
- `rd_en_o` out 1: RAM/ROM read strobe.
- `rd_addr_a_o`, `rd_addr_b_o` out 8: coefficient read addresses.
- `tw_addr_o` out 8: twiddle ROM index.
- `wr_en_o` out 1: write-back strobe.
- `wr_addr_a_o`, `wr_addr_b_o` out 8: write-back addresses (`a_out` / `b_out`).
- `sel_red_o`, `sel_butterfly_o` out 1: latched mode, routed to the butterfly.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start_i`. `sel_red_i` and `sel_butterfly_i` are latched at that edge and held until the next start.
  - RUN issues 128 butterflies, one per cycle, then moves to DRAIN.
  - DRAIN waits D = RD_LAT+BF_LAT cycles. If the last layer is finished it goes to DONE, otherwise back to RUN with the next layer.
  - DONE asserts `done_o` for one cycle, then returns to IDLE.
- Counters:
  - Butterfly counter c: 7 bits, 0..127.
  - Layer length len = 2^s.
  - Forward: s runs 7 down to s_min.
  - Inverse: s runs s_min up to 7.
  - s_min = 1 for Kyber, 0 for Dilithium.
- Addresses per layer (g = c >> s):
  - a = c with a 0 inserted at bit s; b = a | len.
  - Forward twiddle: `tw_addr` = (128 >> s) + g.
  - Inverse twiddle: `tw_addr` = (256 >> s) − 1 − g.
- Twiddle index ranges:
  - Kyber forward covers 1..127; Kyber inverse starts at 127.
  - Dilithium forward covers 1..255; Dilithium inverse starts at 255.
  - Twiddle sign and scaling are owned by the ROM contents, not by this block.
- Write-back: `rd_en`/`rd_addr_a`/`rd_addr_b` go through a D-deep shift register to produce `wr_en`/`wr_addr_a`/`wr_addr_b`.
- DRAIN guarantees that every write of layer L lands before the first read of layer L+1. There is no read-after-write bypass.
- `start_i` while busy is ignored. `start_i` held high in DONE starts nothing; a new start needs IDLE.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters 0; delay line cleared.
- Reset asserted mid-operation aborts immediately. No write is emitted after reset asserts, and RAM contents are left undefined.
- Cycle numbering: `start_i` is sampled high at the end of cycle 0.
  - First `rd_en_o` is in cycle 1; `busy_o` is high from cycle 1.
  - Each layer takes 128 + D cycles.
  - `done_o` is high in cycle layers·(128+D)+1; `busy_o` drops in that same cycle.
- Defaults (D=1):
  - Kyber: `done_o` in cycle 904.
  - Dilithium: `done_o` in cycle 1033.
- `wr_en_o` trails `rd_en_o` by exactly D cycles with identical address pairs. With D=0, writes are same-cycle.
- `tw_addr_o` changes only on group boundaries, aligned with `rd_en_o`.

## Structure
- Package `ntt_pkg`:
  - N=256, LOG_N=8.
  - Layer counts KYBER_LAYERS=7, DIL_LAYERS=8.
  - Mode encodings SEL_KYBER=1, SEL_CT=0.
  - State enum `ntt_state_t`.
- One sub-module: `ntt_addr_gen`, a combinational map (c, s, dir) -> (a, b, tw). The FSM, counters and delay line stay in `ntt_sequencer`.

## Test plan
- Reset, then Kyber forward start:
  - Cycle 1: a=0, b=128, tw=1.
  - Cycle 129: `rd_en` low (DRAIN).
  - Cycle 130: a=0, b=64, tw=2.
  - `done_o` at cycle 904; 896 writes in total.
- Kyber inverse:
  - First butterfly a=0, b=2, tw=127.
  - c=1 gives a=1, b=3, tw=127; c=2 gives a=4, b=6, tw=126.
  - Last layer: a=c, b=c+128, tw=1.
- Dilithium forward:
  - Final layer: c=5 gives a=10, b=11, tw=133.
  - `done_o` at cycle 1033, single pulse.
- Write-back check: with RD_LAT=2, BF_LAT=1, every `wr_addr` pair equals the `rd_addr` pair from 3 cycles earlier, and no read in a layer precedes the last write of the previous layer.
- Reset and start robustness:
  - `rst_n_i` low at cycle 500: all outputs 0 within the same cycle; a fresh start behaves as after power-on.
  - `start_i` pulsed while busy: no effect.
  - Mode inputs toggled mid-run: `sel_*_o` unchanged.
